// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master. One full-duplex transfer of DATA_W bits
//   per accepted start. sck idles low, ss is active-low one-hot, mosi idles 1.
// Latency: accept at T -> done pulse and rx_data at T+1+(2*DATA_W+1)*DIV.
// Backpressure: start is taken only while ready; start while busy is dropped.
// Ports:
//   clock, reset          - system clock; asynchronous active-high reset
//   start/ready           - command handshake (accept = start && ready)
//   tx_data, ss_sel       - word to send and slave index, latched at accept
//   rx_data, done         - received word, updated with the one-cycle done
//   sck, ss, mosi, miso   - SPI pins
// Optional feature: define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in
//   both directions; the default build is MSB-first. Timing is unchanged.

module spi_master_ctrl #(
  parameter int DATA_W = 16,
  parameter int DIV    = 4,
  parameter int NSS    = 8,
  localparam int SEL_W = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              sck,
  output logic [NSS-1:0]    ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;

  logic               tick;
  logic               accept;
  logic [EDGE_W-1:0]  edge_nxt;
  logic               first_bit;
  logic               next_bit;
  logic [DATA_W-1:0]  tx_shifted;
  logic [DATA_W-1:0]  rx_shifted;

  assign tick     = (div_cnt_q == DIV_LAST);
  // The done cycle is already IDLE, but the next command is held off one
  // more clock so ss is guaranteed a high gap between transfers.
  assign ready    = (state_q == S_IDLE) && !done_q;
  assign accept   = start && ready;
  assign edge_nxt = edge_cnt_q + EDGE_W'(1);

  // Shift direction is the only thing the bit-order option changes.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit  = tx_data[0];
  assign next_bit   = tx_sh_q[1];
  assign tx_shifted = tx_sh_q >> 1;
  assign rx_shifted = {miso, rx_sh_q[DATA_W-1:1]};
`else
  assign first_bit  = tx_data[DATA_W-1];
  assign next_bit   = tx_sh_q[DATA_W-2];
  assign tx_shifted = tx_sh_q << 1;
  assign rx_shifted = {rx_sh_q[DATA_W-2:0], miso};
`endif

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    edge_cnt_d = edge_cnt_q;
    sel_d      = sel_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    rx_data_d  = rx_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_sh_d    = tx_data;
          sel_d      = ss_sel;
          rx_sh_d    = '0;
          edge_cnt_d = '0;
          mosi_d     = first_bit;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          sck_d      = 1'b1;
          rx_sh_d    = rx_shifted;
          edge_cnt_d = EDGE_W'(1);
          state_d    = S_XFER;
        end
      end
      S_XFER: begin
        if (tick) begin
          sck_d      = ~sck_q;
          edge_cnt_d = edge_nxt;
          if (edge_nxt[0]) begin
            // rising edge: sample
            rx_sh_d = rx_shifted;
          end else if (edge_nxt == LAST_EDGE) begin
            // final falling edge: no further mosi bit to present
            state_d = S_HOLD;
          end else begin
            tx_sh_d = tx_shifted;
            mosi_d  = next_bit;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          mosi_d    = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider runs only while a transfer is in flight and restarts at every
  // phase boundary so each phase lasts exactly DIV clocks.
  always_comb begin
    if ((state_q == S_IDLE) || (state_d != state_q) || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Selects decode from state so reset releases them in the same cycle; an
  // out-of-range index matches no line and the transfer runs unselected.
  always_comb begin
    ss = '1;
    if (state_q != S_IDLE) begin
      for (int i = 0; i < NSS; i++) begin
        if (sel_q == SEL_W'(i)) begin
          ss[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sel_q      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b1;
      done_q     <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sel_q      <= sel_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with DATA_W=16, DIV=4, NSS=8.
// Cycle k counts clocks after the accept cycle T; outputs are observed 1ns
// after each rising edge, inputs are driven at the same point.

module tb_spi_master_ctrl;

  localparam int DW   = 16;
  localparam int DV   = 4;
  localparam int NS   = 8;
  localparam int MAXK = 200;

  logic          clock;
  logic          reset;
  logic          start;
  logic          ready;
  logic [DW-1:0] tx_data;
  logic [2:0]    ss_sel;
  logic [DW-1:0] rx_data;
  logic          done;
  logic          sck;
  logic [NS-1:0] ss;
  logic          mosi;
  logic          loop_en;
  logic          miso_src;
  logic          miso_w;

  int errors;
  int checks;

  assign miso_w = loop_en ? mosi : miso_src;

  spi_master_ctrl #(.DATA_W(DW), .DIV(DV), .NSS(NS)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ready   (ready),
    .tx_data (tx_data),
    .ss_sel  (ss_sel),
    .rx_data (rx_data),
    .done    (done),
    .sck     (sck),
    .ss      (ss),
    .mosi    (mosi),
    .miso    (miso_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Launches one transfer and records what the pins did, cycle by cycle.
  // Expected sck level at cycle k: number of edges so far = (k-1)/DIV,
  // capped at 2*DW; odd count means high.
  task automatic run_xfer(input logic [DW-1:0] tx, input logic [2:0] sel,
                          input logic lb, input logic mval,
                          output int done_k, output int n_done,
                          output logic [DW-1:0] rx_got, output logic [NS-1:0] ss_first,
                          output int ss_bad, output int sck_bad, output int ready_bad,
                          output int rises, output int first_rise,
                          output int mosi_hi, output logic mosi_first);
    logic prev_sck;
    int   e;
    logic exp_sck;
    done_k = 0; n_done = 0; rx_got = '0; ss_first = '0; ss_bad = 0;
    sck_bad = 0; ready_bad = 0; rises = 0; first_rise = 0; mosi_hi = 0;
    mosi_first = 1'b0;
    loop_en = lb; miso_src = mval; tx_data = tx; ss_sel = sel; start = 1'b1;
    step();
    start = 1'b0; tx_data = ~tx; ss_sel = sel + 3'd1;
    prev_sck = 1'b0;
    for (int k = 1; k <= MAXK; k++) begin
      e = (k - 1) / DV;
      if (e > 2 * DW) e = 2 * DW;
      exp_sck = (e % 2) == 1;
      if (sck !== exp_sck) sck_bad++;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
        rises++;
        if (first_rise == 0) first_rise = k;
      end
      prev_sck = sck;
      if (k == 1) begin
        ss_first   = ss;
        mosi_first = mosi;
      end
      if (k <= 2 * DW * DV && mosi === 1'b1) mosi_hi++;
      if (done === 1'b1) begin
        n_done++;
        if (done_k == 0) begin
          done_k = k;
          rx_got = rx_data;
        end
        if (ss !== 8'hFF) ss_bad++;
        if (ready !== 1'b0) ready_bad++;
      end else if (done_k == 0) begin
        if (ss !== ss_first) ss_bad++;
        if (ready !== 1'b0) ready_bad++;
      end else begin
        if (ready !== 1'b1) ready_bad++;
        if (ss !== 8'hFF) ss_bad++;
        if (k >= done_k + 2) break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    int done_seen;
    done_seen = 0;
    reset = 1'b1; start = 1'b0; tx_data = '0; ss_sel = '0;
    loop_en = 1'b0; miso_src = 1'b0;
    #2;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (ss !== 8'hFF) begin errors++; $display("FAIL rst_ss got=%h exp=ff", ss); end
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck got=%b exp=0", sck); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi got=%b exp=1", mosi); end
    checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL rst_rx got=%h exp=0000", rx_data); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL idle_done got=%0d exp=0", done_seen); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", ready); end
    checks++; if (ss !== 8'hFF) begin errors++; $display("FAIL idle_ss got=%h exp=ff", ss); end
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL idle_sck got=%b exp=0", sck); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL idle_mosi got=%b exp=1", mosi); end
  endtask

  task automatic test_loopback();
    int dk, nd, sb, kb, rb, ri, fr, mh;
    logic [DW-1:0] rx;
    logic [NS-1:0] sf;
    logic mf;
    run_xfer(16'hA53C, 3'd2, 1'b1, 1'b0, dk, nd, rx, sf, sb, kb, rb, ri, fr, mh, mf);
    checks++; if (dk !== 133) begin errors++; $display("FAIL lb_done_cycle got=%0d exp=133", dk); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL lb_done_pulses got=%0d exp=1", nd); end
    checks++; if (rx !== 16'hA53C) begin errors++; $display("FAIL lb_rx got=%h exp=a53c", rx); end
    checks++; if (sf !== 8'hFB) begin errors++; $display("FAIL lb_ss got=%h exp=fb", sf); end
    checks++; if (sb !== 0) begin errors++; $display("FAIL lb_ss_stable got=%0d bad cycles exp=0", sb); end
    checks++; if (kb !== 0) begin errors++; $display("FAIL lb_sck_timing got=%0d bad cycles exp=0", kb); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL lb_ready got=%0d bad cycles exp=0", rb); end
    checks++; if (ri !== 16) begin errors++; $display("FAIL lb_rises got=%0d exp=16", ri); end
    checks++; if (fr !== 5) begin errors++; $display("FAIL lb_first_rise got=%0d exp=5", fr); end
    checks++; if (mh !== 64) begin errors++; $display("FAIL lb_mosi_hi got=%0d exp=64", mh); end
    checks++; if (mf !== 1'b1) begin errors++; $display("FAIL lb_mosi_first got=%b exp=1", mf); end
  endtask

  task automatic test_const_miso();
    int dk, nd, sb, kb, rb, ri, fr, mh;
    logic [DW-1:0] rx;
    logic [NS-1:0] sf;
    logic mf;
    run_xfer(16'h0000, 3'd7, 1'b0, 1'b1, dk, nd, rx, sf, sb, kb, rb, ri, fr, mh, mf);
    checks++; if (rx !== 16'hFFFF) begin errors++; $display("FAIL miso1_rx got=%h exp=ffff", rx); end
    checks++; if (mh !== 0) begin errors++; $display("FAIL miso1_mosi_hi got=%0d exp=0", mh); end
    checks++; if (sf !== 8'h7F) begin errors++; $display("FAIL miso1_ss got=%h exp=7f", sf); end
    checks++; if (dk !== 133) begin errors++; $display("FAIL miso1_done got=%0d exp=133", dk); end
    run_xfer(16'hFFFF, 3'd0, 1'b0, 1'b0, dk, nd, rx, sf, sb, kb, rb, ri, fr, mh, mf);
    checks++; if (rx !== 16'h0000) begin errors++; $display("FAIL miso0_rx got=%h exp=0000", rx); end
    checks++; if (mh !== 128) begin errors++; $display("FAIL miso0_mosi_hi got=%0d exp=128", mh); end
    checks++; if (sf !== 8'hFE) begin errors++; $display("FAIL miso0_ss got=%h exp=fe", sf); end
    checks++; if (kb !== 0) begin errors++; $display("FAIL miso0_sck got=%0d bad cycles exp=0", kb); end
  endtask

  // start stays high: second accept lands the cycle after the first done
  // becomes ready again (k=134), so the second done is at 134+133=267.
  task automatic test_back_to_back();
    int n_done, d1, d2, ready_bad, gap;
    logic gap_open;
    logic [DW-1:0] rx1, rx2;
    n_done = 0; d1 = 0; d2 = 0; ready_bad = 0; gap = 0; gap_open = 1'b0;
    rx1 = '0; rx2 = '0;
    loop_en = 1'b1; tx_data = 16'h1234; ss_sel = 3'd1; start = 1'b1;
    step();
    for (int k = 1; k <= 320; k++) begin
      if (done === 1'b1) begin
        n_done++;
        if (d1 == 0) begin
          d1 = k; rx1 = rx_data; gap_open = 1'b1;
        end else if (d2 == 0) begin
          d2 = k; rx2 = rx_data; start = 1'b0;
        end
      end
      if (gap_open) begin
        if (ss === 8'hFF) gap++;
        else gap_open = 1'b0;
      end
      if (ready === 1'b1 && ((k >= 1 && k <= 133) || (k >= 135 && k <= 267))) ready_bad++;
      if (ready !== 1'b1 && (k == 134 || k >= 268)) ready_bad++;
      step();
    end
    start = 1'b0;
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", n_done); end
    checks++; if (d1 !== 133) begin errors++; $display("FAIL b2b_done1 got=%0d exp=133", d1); end
    checks++; if (d2 !== 267) begin errors++; $display("FAIL b2b_done2 got=%0d exp=267", d2); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL b2b_ready got=%0d bad cycles exp=0", ready_bad); end
    checks++; if (gap < 1) begin errors++; $display("FAIL b2b_ss_gap got=%0d exp>=1", gap); end
    checks++; if (rx2 !== 16'h1234) begin errors++; $display("FAIL b2b_rx2 got=%h exp=1234", rx2); end
    checks++; if (rx1 !== 16'h1234) begin errors++; $display("FAIL b2b_rx1 got=%h exp=1234", rx1); end
  endtask

  task automatic test_reset_midxfer();
    int dk, nd, sb, kb, rb, ri, fr, mh, done_seen;
    logic [DW-1:0] rx;
    logic [NS-1:0] sf;
    logic mf;
    done_seen = 0;
    loop_en = 1'b1; tx_data = 16'hA53C; ss_sel = 3'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 40; k++) step();
    // cycle T+40: 9 edges so far, sck high, mid XFER
    checks++; if (sck !== 1'b1) begin errors++; $display("FAIL mid_sck_pre got=%b exp=1", sck); end
    reset = 1'b1;
    #1;
    checks++; if (ss !== 8'hFF) begin errors++; $display("FAIL mid_ss got=%h exp=ff", ss); end
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL mid_sck got=%b exp=0", sck); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
    checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL mid_rx got=%h exp=0000", rx_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    reset = 1'b0;
    for (int i = 0; i < 140; i++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
    checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL mid_rx_kept got=%h exp=0000", rx_data); end
    run_xfer(16'h3C5A, 3'd5, 1'b1, 1'b0, dk, nd, rx, sf, sb, kb, rb, ri, fr, mh, mf);
    checks++; if (dk !== 133) begin errors++; $display("FAIL post_done got=%0d exp=133", dk); end
    checks++; if (rx !== 16'h3C5A) begin errors++; $display("FAIL post_rx got=%h exp=3c5a", rx); end
    checks++; if (sf !== 8'hDF) begin errors++; $display("FAIL post_ss got=%h exp=df", sf); end
  endtask

  // 0x0001 in loopback: one mosi-high bit lasting 8 clocks in either order;
  // it is the first bit only when LSB-first.
  task automatic test_bit_order();
    int dk, nd, sb, kb, rb, ri, fr, mh;
    logic [DW-1:0] rx;
    logic [NS-1:0] sf;
    logic mf;
    logic exp_first;
`ifdef SPI_MASTER_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    run_xfer(16'h0001, 3'd3, 1'b1, 1'b0, dk, nd, rx, sf, sb, kb, rb, ri, fr, mh, mf);
    checks++; if (rx !== 16'h0001) begin errors++; $display("FAIL order_rx got=%h exp=0001", rx); end
    checks++; if (mf !== exp_first) begin errors++; $display("FAIL order_first got=%b exp=%b", mf, exp_first); end
    checks++; if (mh !== 8) begin errors++; $display("FAIL order_mosi_hi got=%0d exp=8", mh); end
    checks++; if (sf !== 8'hF7) begin errors++; $display("FAIL order_ss got=%h exp=f7", sf); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_loopback();
    test_const_miso();
    test_back_to_back();
    test_reset_midxfer();
    test_bit_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI mode-0 master that generates `sck`/`ss`/`mosi` and samples `miso` for the peripheral SPI slaves, including the bit-reversal test slave. It sits directly upstream of those slaves. A simple start/ready command port from the core-side bus adapter launches one full-duplex transfer of `DATA_W` bits. On completion it returns the received word with a one-cycle `done` pulse.

## Interface
Parameters:
- `DATA_W`, 16: bits per transfer, ≥2.
- `DIV`, 4: system clocks per `sck` half-period, ≥1.
- `NSS`, 8: number of slave-select lines, ≥1.

Ports:
- `clock` in 1: system clock. One clock domain; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a transfer. Accepted when `start && ready`.
- `ready` out 1: high only in IDLE.
- `tx_data` in `DATA_W`: word to send. Latched at accept.
- `ss_sel` in `$clog2(NSS)` (min 1): slave index. Latched at accept.
- `rx_data` out `DATA_W`: received word. Updated only at `done`.
- `done` out 1: one-cycle pulse at end of transfer.
- `sck` out 1: SPI clock. Idles low.
- `ss` out `NSS`: active-low selects. Idle all ones.
- `mosi` out 1: serial out. Idles 1.
- `miso` in 1: serial in.

## Operation
- Registers: `tx_sh` (DATA_W), `rx_sh` (DATA_W), `div_cnt` (0..DIV-1), `edge_cnt` (0..2*DATA_W), `sel_q`.
- A `tick` occurs when `div_cnt == DIV-1`. `div_cnt` clears on every state change and on every tick.
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE: `ready`=1. On accept:
  - latch `tx_data` into `tx_sh` and `ss_sel` into `sel_q`;
  - clear `rx_sh` and `edge_cnt`;
  - go to SETUP.
- SETUP:
  - `ss[sel_q]`=0; `mosi` = first bit of `tx_sh`.
  - On tick: raise `sck`, sample `miso` into `rx_sh`, set `edge_cnt`=1, go to XFER.
- XFER, on each tick:
  - toggle `sck` and increment `edge_cnt`;
  - on a rising edge (odd `edge_cnt` after increment): shift `miso` into `rx_sh`;
  - on a falling edge: shift `tx_sh` and drive the next bit on `mosi`.
- XFER ends when `edge_cnt` reaches 2*DATA_W, i.e. on the final falling edge: `sck`=0 and the state goes to HOLD. `mosi` is not updated on that final falling edge.
- HOLD, on tick:
  - `ss` all ones, `mosi`=1;
  - `rx_data` ← `rx_sh` with the final bit already included;
  - `done`=1 for exactly this cycle;
  - go to IDLE.
- Bit order is MSB-first, both directions. See Configuration.
- `start` while not `ready` is ignored, not queued. `tx_data` and `ss_sel` changes after accept have no effect.
- `ss_sel ≥ NSS`: the transfer runs with full timing but all `ss` stay high. `rx_data` receives whatever `miso` carries.
- `ss` is one-hot-low at most; never more than one line is low.

## Timing
- Accept at cycle T. Then:
  - `ready`=0 and `ss[sel]`=0 from T+1;
  - `sck` edge m (m=1..2*DATA_W) occurs at T+1+m·DIV; odd m is a rising edge;
  - `done`=1, `rx_data` valid, and `ss` high at T+1+(2*DATA_W+1)·DIV;
  - `ready`=1 from the cycle after `done`.
- Earliest next accept is the cycle after `done`. Back-to-back transfers keep `ss` high for at least one clock.
- `miso` is sampled in the same clock in which `sck` rises. `mosi` changes in the same clock in which `sck` falls, and at SETUP entry.
- Reset values, taking effect immediately (asynchronous): state IDLE, `ready`=1, `done`=0, `rx_data`=0, `sck`=0, `ss`=all ones, `mosi`=1, all counters 0.
- Reset mid-transfer aborts immediately: no `done` pulse, `rx_data` keeps 0, and `ss` rises in the same cycle.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - defined: `tx_sh` shifts right and `mosi` carries bit 0 first; `miso` enters at the MSB and shifts right, so the first received bit lands in bit 0 at completion;
  - undefined: MSB-first on both `mosi` and `miso`.
- Cycle timing is identical either way.

## Test plan
- Reset, then idle 20 cycles → `ready`=1, `ss`=8'hFF, `sck`=0, `mosi`=1, `done` never asserted.
- Loopback (`miso`=`mosi`), DIV=4, DATA_W=16, `tx_data`=16'hA53C, `ss_sel`=2 →
  - `ss`=8'hFB from T+1;
  - 16 `sck` rising edges, at T+5, T+13, …;
  - `done` at T+133 with `rx_data`=16'hA53C.
- `miso` tied 1, `tx_data`=0 → `mosi` low during XFER, `rx_data`=16'hFFFF. Then `miso` tied 0 → `rx_data`=16'h0000.
- `start` held high throughout two transfers →
  - exactly two `done` pulses;
  - `ready` is low between accept and `done`;
  - `ss` is high for ≥1 cycle between transfers.
- Assert `reset` at T+40 during XFER → same cycle: `ss`=8'hFF, `sck`=0, no `done`. After release, a new transfer completes normally.
- With `SPI_MASTER_LSB_FIRST_EN`, loopback `tx_data`=16'h0001 → `mosi`=1 on the first bit only, `rx_data`=16'h0001.
